// File: rtl/hazard_if.sv
// Hazard-unit bundle: per-stage pipeline controls/specifiers in, stall/flush/forward decisions out.
interface hazard_if #(
    parameter int STALL_CNT_W = 16
);
    logic [4:0]             rs_d;
    logic [4:0]             rt_d;
    logic [4:0]             rs_e;
    logic [4:0]             rt_e;
    logic [4:0]             writereg_e;
    logic [4:0]             writereg_m;
    logic [4:0]             writereg_w;
    logic                   regwrite_e;
    logic                   regwrite_m;
    logic                   regwrite_w;
    logic                   memtoreg_e;
    logic                   memtoreg_m;
    logic                   branch_d;
    logic                   bne_d;
    logic                   jr_d;
    logic                   hien_e;
    logic                   loen_e;
    logic                   mfhi_d;
    logic                   mflo_d;
    logic                   mdu_d;
    logic                   stall_f;
    logic                   stall_d;
    logic                   flush_e;
    logic                   forward_ad;
    logic                   forward_bd;
    logic [1:0]             forward_ae;
    logic [1:0]             forward_be;
    logic                   mdu_busy;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
               regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
               branch_d, bne_d, jr_d, hien_e, loen_e, mfhi_d, mflo_d, mdu_d,
        input  stall_f, stall_d, flush_e, forward_ad, forward_bd,
               forward_ae, forward_be, mdu_busy, stall_count
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
               regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
               branch_d, bne_d, jr_d, hien_e, loen_e, mfhi_d, mflo_d, mdu_d,
        output stall_f, stall_d, flush_e, forward_ad, forward_bd,
               forward_ae, forward_be, mdu_busy, stall_count
    );
endinterface

// File: rtl/hazard_unit.sv
// 5-stage MIPS hazard resolver: load-use / branch / HI-LO stalls, E and D forwarding,
// multi-cycle MDU busy tracking and a saturating stalled-cycle counter.
module hazard_unit #(
    parameter int MDU_LATENCY = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  hz
);
    localparam logic [3:0]             MDU_LOAD  = 4'(MDU_LATENCY - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]             mdu_cnt_q;
    logic [3:0]             mdu_cnt_d;
    logic [STALL_CNT_W-1:0] stall_count_q;
    logic [STALL_CNT_W-1:0] stall_count_d;
    logic                   lwstall_s;
    logic                   brstall_s;
    logic                   mdustall_s;
    logic                   stall_s;
    logic                   mdu_busy_s;
    logic                   br_dep_s;
    logic                   jr_dep_s;

    // $0 is hard-wired, so a zero specifier never creates a dependency
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (hz.regwrite_m && reg_match(src, hz.writereg_m)) begin
            return 2'b10;
        end else if (hz.regwrite_w && reg_match(src, hz.writereg_w)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign lwstall_s = hz.memtoreg_e &
                       (reg_match(hz.rs_d, hz.writereg_e) | reg_match(hz.rt_d, hz.writereg_e));

    assign br_dep_s = (hz.regwrite_e & (reg_match(hz.rs_d, hz.writereg_e) |
                                        reg_match(hz.rt_d, hz.writereg_e))) |
                      (hz.memtoreg_m & (reg_match(hz.rs_d, hz.writereg_m) |
                                        reg_match(hz.rt_d, hz.writereg_m)));
    assign jr_dep_s = (hz.regwrite_e & reg_match(hz.rs_d, hz.writereg_e)) |
                      (hz.memtoreg_m & reg_match(hz.rs_d, hz.writereg_m));
    assign brstall_s = ((hz.branch_d | hz.bne_d) & br_dep_s) | (hz.jr_d & jr_dep_s);

    assign mdu_busy_s = hz.hien_e | hz.loen_e | (mdu_cnt_q != 4'd0);
    assign mdustall_s = mdu_busy_s & (hz.mfhi_d | hz.mflo_d | hz.mdu_d);
    assign stall_s    = lwstall_s | brstall_s | mdustall_s;

    // MDU countdown: a mult/div in E reloads it; a flushed bubble carries no enables
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (hz.hien_e || hz.loen_e) begin
            mdu_cnt_d = MDU_LOAD;
        end else if (mdu_cnt_q != 4'd0) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end else begin
            mdu_cnt_d = mdu_cnt_q;
        end
    end

    // Stall performance counter, sticks at all-ones
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_s && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + STALL_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_cnt_q     <= 4'd0;
            stall_count_q <= {STALL_CNT_W{1'b0}};
        end else begin
            mdu_cnt_q     <= mdu_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.stall_f     = stall_s;
    assign hz.stall_d     = stall_s;
    assign hz.flush_e     = stall_s;
    assign hz.forward_ad  = hz.regwrite_m & reg_match(hz.rs_d, hz.writereg_m);
    assign hz.forward_bd  = hz.regwrite_m & reg_match(hz.rt_d, hz.writereg_m);
    assign hz.forward_ae  = fwd_sel(hz.rs_e);
    assign hz.forward_be  = fwd_sel(hz.rt_e);
    assign hz.mdu_busy    = mdu_busy_s;
    assign hz.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a cycle-level reference model and per-cycle comparison.
module tb_hazard_unit;
    localparam int L  = 4;
    localparam int CW = 4;
    localparam int SMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_mult = -1000;
    int   scount = 0;

    hazard_if #(.STALL_CNT_W(CW)) hif ();

    hazard_unit #(.MDU_LATENCY(L), .STALL_CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic int m_fwd(input logic [4:0] src);
        if (hif.regwrite_m && m(src, hif.writereg_m)) return 2;
        if (hif.regwrite_w && m(src, hif.writereg_w)) return 1;
        return 0;
    endfunction

    // Busy while a mult/div sits in E or fewer than L cycles have passed since it left E
    function automatic bit m_busy();
        int age;
        age = cyc - last_mult;
        return hif.hien_e || hif.loen_e || (rst_n && age >= 1 && age <= L - 1);
    endfunction

    function automatic bit m_stall();
        bit lw, br, jr, md;
        lw = hif.memtoreg_e && (m(hif.rs_d, hif.writereg_e) || m(hif.rt_d, hif.writereg_e));
        br = (hif.branch_d || hif.bne_d) &&
             ((hif.regwrite_e && (m(hif.rs_d, hif.writereg_e) || m(hif.rt_d, hif.writereg_e))) ||
              (hif.memtoreg_m && (m(hif.rs_d, hif.writereg_m) || m(hif.rt_d, hif.writereg_m))));
        jr = hif.jr_d && ((hif.regwrite_e && m(hif.rs_d, hif.writereg_e)) ||
                          (hif.memtoreg_m && m(hif.rs_d, hif.writereg_m)));
        md = m_busy() && (hif.mfhi_d || hif.mflo_d || hif.mdu_d);
        return lw || br || jr || md;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_mult <= -1000;
            scount    <= 0;
        end else begin
            if (hif.hien_e || hif.loen_e) last_mult <= cyc;
            if (m_stall() && scount < SMAX) scount <= scount + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("stallF", int'(hif.stall_f), int'(m_stall()));
        chk("stallD", int'(hif.stall_d), int'(m_stall()));
        chk("flushE", int'(hif.flush_e), int'(m_stall()));
        chk("forwardAD", int'(hif.forward_ad), int'(hif.regwrite_m && m(hif.rs_d, hif.writereg_m)));
        chk("forwardBD", int'(hif.forward_bd), int'(hif.regwrite_m && m(hif.rt_d, hif.writereg_m)));
        chk("forwardAE", int'(hif.forward_ae), m_fwd(hif.rs_e));
        chk("forwardBE", int'(hif.forward_be), m_fwd(hif.rt_e));
        chk("mdu_busy", int'(hif.mdu_busy), int'(m_busy()));
        chk("stall_count", int'(hif.stall_count), rst_n ? scount : 0);
    end

    task automatic clr();
        hif.rs_d = 5'd0; hif.rt_d = 5'd0; hif.rs_e = 5'd0; hif.rt_e = 5'd0;
        hif.writereg_e = 5'd0; hif.writereg_m = 5'd0; hif.writereg_w = 5'd0;
        hif.regwrite_e = 1'b0; hif.regwrite_m = 1'b0; hif.regwrite_w = 1'b0;
        hif.memtoreg_e = 1'b0; hif.memtoreg_m = 1'b0;
        hif.branch_d = 1'b0; hif.bne_d = 1'b0; hif.jr_d = 1'b0;
        hif.hien_e = 1'b0; hif.loen_e = 1'b0;
        hif.mfhi_d = 1'b0; hif.mflo_d = 1'b0; hif.mdu_d = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        clr();
        #3;
        chk("reset stall", int'(hif.stall_f), 0);
        chk("reset busy", int'(hif.mdu_busy), 0);
        chk("reset count", int'(hif.stall_count), 0);
        step();
        rst_n = 1'b1;

        // E-stage forwarding priorities
        step(); hif.rs_e = 5'd1; hif.rt_e = 5'd1; hif.regwrite_m = 1'b1; hif.writereg_m = 5'd1; #2;
        chk("fwdAE M", int'(hif.forward_ae), 2);
        chk("fwdBE M", int'(hif.forward_be), 2);
        step(); hif.rs_e = 5'd1; hif.regwrite_w = 1'b1; hif.writereg_w = 5'd1; #2;
        chk("fwdAE W", int'(hif.forward_ae), 1);
        step(); hif.rs_e = 5'd1; hif.regwrite_m = 1'b1; hif.writereg_m = 5'd1;
        hif.regwrite_w = 1'b1; hif.writereg_w = 5'd1; #2;
        chk("fwdAE M over W", int'(hif.forward_ae), 2);
        step(); hif.rs_e = 5'd0; hif.regwrite_m = 1'b1; hif.writereg_m = 5'd0; #2;
        chk("fwdAE r0", int'(hif.forward_ae), 0);

        // Load-use stall
        step(); hif.memtoreg_e = 1'b1; hif.regwrite_e = 1'b1; hif.writereg_e = 5'd2; hif.rs_d = 5'd2; #2;
        chk("lw stallF", int'(hif.stall_f), 1);
        chk("lw flushE", int'(hif.flush_e), 1);
        step(); #2;
        chk("lw stall drop", int'(hif.stall_d), 0);
        chk("lw count", int'(hif.stall_count), 1);

        // Branch / jr dependencies
        step(); hif.branch_d = 1'b1; hif.rs_d = 5'd3; hif.regwrite_e = 1'b1; hif.writereg_e = 5'd3; #2;
        chk("beq E stall", int'(hif.stall_f), 1);
        step(); hif.branch_d = 1'b1; hif.rs_d = 5'd3; hif.regwrite_m = 1'b1; hif.writereg_m = 5'd3; #2;
        chk("beq fwdAD", int'(hif.forward_ad), 1);
        chk("beq M no stall", int'(hif.stall_f), 0);
        step(); hif.jr_d = 1'b1; hif.rs_d = 5'd5; hif.memtoreg_m = 1'b1; hif.regwrite_m = 1'b1;
        hif.writereg_m = 5'd5; #2;
        chk("jr lw stall", int'(hif.stall_f), 1);

        // mfhi behind a mult stalls exactly L cycles
        step(); hif.hien_e = 1'b1; hif.mfhi_d = 1'b1; #2;
        chk("mdu t stall", int'(hif.stall_f), 1);
        for (int k = 1; k < L; k++) begin
            step(); hif.mfhi_d = 1'b1; #2;
            chk("mdu hold stall", int'(hif.stall_f), 1);
            chk("mdu hold busy", int'(hif.mdu_busy), 1);
        end
        step(); hif.mfhi_d = 1'b1; #2;
        chk("mdu release stall", int'(hif.stall_f), 0);
        chk("mdu release busy", int'(hif.mdu_busy), 0);

        // Unrelated instruction behind a mult
        step(); hif.hien_e = 1'b1; hif.rs_d = 5'd7; hif.rt_d = 5'd8; #2;
        chk("mult+add stall", int'(hif.stall_f), 0);
        chk("mult+add busy", int'(hif.mdu_busy), 1);
        for (int k = 0; k < L; k++) step();

        // Reset in the middle of an MDU wait
        step(); hif.loen_e = 1'b1; hif.mflo_d = 1'b1;
        step(); hif.mflo_d = 1'b1; rst_n = 1'b0; #2;
        chk("rst busy", int'(hif.mdu_busy), 0);
        chk("rst stall", int'(hif.stall_f), 0);
        chk("rst count", int'(hif.stall_count), 0);
        step(); rst_n = 1'b1;

        // Saturation of the stall counter
        for (int k = 0; k < 20; k++) begin
            step(); hif.memtoreg_e = 1'b1; hif.writereg_e = 5'd9; hif.rt_d = 5'd9; #2;
            if (k == 15) chk("count at 15", int'(hif.stall_count), SMAX);
        end
        step(); #2;
        chk("count saturated", int'(hif.stall_count), SMAX);

        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
